// File: rtl/mem_stream_pkg.sv
// Shared field layout and sel->destination map for the tagged 52-bit memory stream.
// Used by both the transmit-side port mux and the receive-side demux.
package mem_stream_pkg;

  localparam int NDEST    = 12;
  localparam int STREAM_W = 52;
  localparam int DAT_W    = 45;
  localparam int BX_MSB   = 51;
  localparam int BX_LSB   = 49;
  localparam int SEL_MSB  = 48;
  localparam int SEL_LSB  = 45;

  // Returns {valid, index[3:0]}; 1010 and 1101..1111 have no destination.
  function automatic logic [4:0] sel2dest(input logic [3:0] sel);
    logic [4:0] r;
    r = 5'b0;
    if (sel <= 4'd9) begin
      r = {1'b1, sel};
    end else if (sel == 4'd11) begin
      r = {1'b1, 4'd10};
    end else if (sel == 4'd12) begin
      r = {1'b1, 4'd11};
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_wr_counter.sv
// Per-destination saturating write counter with sticky overflow, cleared at BX change.
// Updates on the edge that accepts the word; no backpressure (drops at saturation).
module mem_wr_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W:0]   cnt,
  output logic              ovf
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] cnt_q, cnt_d, cnt_base;
  logic            ovf_q, ovf_d;

  // Clear applies first so a word arriving with a BX change counts from zero.
  always_comb begin
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    ovf_d    = clr ? 1'b0 : ovf_q;
    if (inc) begin
      if (cnt_base == FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_base + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mem_demux.sv
// Receive-side demux: routes tagged words to 12 memories, tracks BX boundaries.
// One-cycle latency, one word per cycle; never stalls (full destinations drop words).
module mem_demux
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stream_valid,
  input  logic [STREAM_W-1:0]           mem_dat_stream,
  output logic [NDEST-1:0]              wr_en,
  output logic [NDEST*ADDR_W-1:0]       wr_addr,
  output logic [DAT_W-1:0]              wr_dat,
  output logic [2:0]                    wr_bx,
  output logic                          bx_new,
  output logic [NDEST*(ADDR_W+1)-1:0]   nent_prev,
  output logic [NDEST-1:0]              ovf,
  output logic                          err_sel
);

  localparam int              CW   = ADDR_W + 1;
  localparam logic [CW-1:0]   FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]          bx_in;
  logic [3:0]          sel_in;
  logic [DAT_W-1:0]    dat_in;
  logic [4:0]          dec;
  logic                sel_ok;
  logic [3:0]          dest;
  logic                bx_chg;
  logic [NDEST-1:0]    inc;
  logic [NDEST*CW-1:0] cnt_flat;

  logic [2:0]                cur_bx_q, cur_bx_d;
  logic [NDEST-1:0]          wr_en_q, wr_en_d;
  logic [NDEST*ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DAT_W-1:0]          wr_dat_q, wr_dat_d;
  logic [2:0]                wr_bx_q, wr_bx_d;
  logic                      bx_new_q, bx_new_d;
  logic [NDEST*CW-1:0]       nent_prev_q, nent_prev_d;
  logic                      err_sel_q, err_sel_d;

  assign bx_in  = mem_dat_stream[BX_MSB:BX_LSB];
  assign sel_in = mem_dat_stream[SEL_MSB:SEL_LSB];
  assign dat_in = mem_dat_stream[DAT_W-1:0];
  assign dec    = sel2dest(sel_in);
  assign sel_ok = dec[4];
  assign dest   = dec[3:0];
  assign bx_chg = stream_valid && (bx_in != cur_bx_q);

  always_comb begin
    inc = '0;
    for (int i = 0; i < NDEST; i++) begin
      inc[i] = stream_valid && sel_ok && (dest == 4'(i));
    end
  end

  for (genvar g = 0; g < NDEST; g++) begin : g_cnt
    mem_wr_counter #(.ADDR_W(ADDR_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (bx_chg),
      .inc     (inc[g]),
      .cnt     (cnt_flat[g*CW +: CW]),
      .ovf     (ovf[g])
    );
  end

  always_comb begin
    cur_bx_d    = bx_chg ? bx_in : cur_bx_q;
    wr_en_d     = '0;
    wr_addr_d   = wr_addr_q;
    wr_dat_d    = wr_dat_q;
    wr_bx_d     = wr_bx_q;
    bx_new_d    = bx_chg;
    err_sel_d   = stream_valid && !sel_ok;
    nent_prev_d = bx_chg ? cnt_flat : nent_prev_q;
    if (stream_valid) begin
      wr_dat_d = dat_in;
      wr_bx_d  = bx_in;
    end
    // A BX change empties the target counter before the word is placed.
    for (int i = 0; i < NDEST; i++) begin
      if (inc[i] && (bx_chg || (cnt_flat[i*CW +: CW] != FULL))) begin
        wr_en_d[i] = 1'b1;
        wr_addr_d[i*ADDR_W +: ADDR_W] = bx_chg ? '0 : cnt_flat[i*CW +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_bx_q    <= '0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_dat_q    <= '0;
      wr_bx_q     <= '0;
      bx_new_q    <= 1'b0;
      nent_prev_q <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      cur_bx_q    <= cur_bx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_dat_q    <= wr_dat_d;
      wr_bx_q     <= wr_bx_d;
      bx_new_q    <= bx_new_d;
      nent_prev_q <= nent_prev_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_dat    = wr_dat_q;
  assign wr_bx     = wr_bx_q;
  assign bx_new    = bx_new_q;
  assign nent_prev = nent_prev_q;
  assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_mem_demux.sv
// Directed bench for mem_demux: routing, invalid sels, overflow, BX boundaries, wrap, reset.
module tb_mem_demux;

  localparam int AW = 6;
  localparam int CW = AW + 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stream_valid;
  logic [51:0]     mem_dat_stream;
  logic [11:0]     wr_en;
  logic [12*AW-1:0] wr_addr;
  logic [44:0]     wr_dat;
  logic [2:0]      wr_bx;
  logic            bx_new;
  logic [12*CW-1:0] nent_prev;
  logic [11:0]     ovf;
  logic            err_sel;

  int n_tests = 0;
  int n_fail  = 0;

  mem_demux #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stream_valid   (stream_valid),
    .mem_dat_stream (mem_dat_stream),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_dat         (wr_dat),
    .wr_bx          (wr_bx),
    .bx_new         (bx_new),
    .nent_prev      (nent_prev),
    .ovf            (ovf),
    .err_sel        (err_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int d);
    return wr_addr[d*AW +: AW];
  endfunction

  function automatic logic [CW-1:0] nent_of(input int d);
    return nent_prev[d*CW +: CW];
  endfunction

  // One word per call; outputs for that word are visible on return.
  task automatic step(input logic vld, input logic [2:0] bx, input logic [3:0] sel,
                      input logic [44:0] dat);
    stream_valid   = vld;
    mem_dat_stream = {bx, sel, dat};
    @(posedge clk);
    #1;
    stream_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    stream_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wr_en"},     96'(wr_en),     96'd0);
    check({tag, " wr_addr"},   96'(wr_addr),   96'd0);
    check({tag, " wr_dat"},    96'(wr_dat),    96'd0);
    check({tag, " wr_bx"},     96'(wr_bx),     96'd0);
    check({tag, " bx_new"},    96'(bx_new),    96'd0);
    check({tag, " nent_prev"}, 96'(nent_prev), 96'd0);
    check({tag, " ovf"},       96'(ovf),       96'd0);
    check({tag, " err_sel"},   96'(err_sel),   96'd0);
  endtask

  initial begin
    logic [12*CW-1:0] e_nent;
    logic [3:0]       rt_sel [4];
    logic [11:0]      rt_en  [4];
    int               rt_dst [4];
    logic [3:0]       bad_sel [3];

    rt_sel = '{4'd0, 4'd5, 4'd11, 4'd12};
    rt_en  = '{12'h001, 12'h020, 12'h400, 12'h800};
    rt_dst = '{0, 5, 10, 11};
    bad_sel = '{4'd10, 4'd13, 4'd15};

    mem_dat_stream = '0;
    do_reset();
    check_zero("reset");

    // Routing at BX=1
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 3'd1, rt_sel[k], 45'h1_0000_0000 + 45'(k));
      check($sformatf("route%0d wr_en", k), 96'(wr_en), 96'(rt_en[k]));
      check($sformatf("route%0d addr", k), 96'(addr_of(rt_dst[k])), 96'd0);
      check($sformatf("route%0d bx_new", k), 96'(bx_new), 96'(k == 0));
      check($sformatf("route%0d wr_dat", k), 96'(wr_dat), 96'(45'h1_0000_0000 + 45'(k)));
      check($sformatf("route%0d wr_bx", k), 96'(wr_bx), 96'd1);
    end

    // Invalid sels at BX=0 straight after reset
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd0, bad_sel[k], 45'h55);
      check($sformatf("inv%0d err_sel", k), 96'(err_sel), 96'd1);
      check($sformatf("inv%0d wr_en", k), 96'(wr_en), 96'd0);
      check($sformatf("inv%0d bx_new", k), 96'(bx_new), 96'd0);
    end
    step(1'b1, 3'd0, 4'd0, 45'h66);
    check("inv_after wr_en", 96'(wr_en), 96'h001);
    check("inv_after addr0", 96'(addr_of(0)), 96'd0);
    check("inv_after err_sel", 96'(err_sel), 96'd0);

    // Overflow of destination 3 at BX=2
    do_reset();
    for (int k = 0; k < 66; k++) begin
      step(1'b1, 3'd2, 4'd3, 45'(k));
      if (k < 64) begin
        check($sformatf("ovf w%0d wr_en", k), 96'(wr_en), 96'h008);
        check($sformatf("ovf w%0d addr", k), 96'(addr_of(3)), 96'(k));
        check($sformatf("ovf w%0d ovf", k), 96'(ovf), 96'd0);
      end else begin
        check($sformatf("ovf w%0d wr_en", k), 96'(wr_en), 96'd0);
        check($sformatf("ovf w%0d ovf", k), 96'(ovf), 96'h008);
      end
    end
    step(1'b1, 3'd3, 4'd3, 45'h77);
    e_nent = '0;
    e_nent[3*CW +: CW] = 7'd64;
    check("ovf next bx_new", 96'(bx_new), 96'd1);
    check("ovf next nent_prev", 96'(nent_prev), 96'(e_nent));
    check("ovf next ovf", 96'(ovf), 96'd0);
    check("ovf next wr_en", 96'(wr_en), 96'h008);
    check("ovf next addr", 96'(addr_of(3)), 96'd0);

    // BX boundary: 5 words to dest 2 at BX=4, then BX=5
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 3'd4, 4'd2, 45'(100 + k));
      check($sformatf("bnd w%0d addr", k), 96'(addr_of(2)), 96'(k));
    end
    check("bnd bx4 nent3", 96'(nent_of(3)), 96'd1);
    step(1'b1, 3'd5, 4'd2, 45'h88);
    e_nent = '0;
    e_nent[2*CW +: CW] = 7'd5;
    check("bnd bx_new", 96'(bx_new), 96'd1);
    check("bnd nent_prev", 96'(nent_prev), 96'(e_nent));
    check("bnd wr_en", 96'(wr_en), 96'h004);
    check("bnd addr", 96'(addr_of(2)), 96'd0);

    // Wrap 7 -> 0
    step(1'b1, 3'd7, 4'd0, 45'h1);
    check("wrap bx7 bx_new", 96'(bx_new), 96'd1);
    step(1'b1, 3'd0, 4'd0, 45'h2);
    check("wrap bx0 bx_new", 96'(bx_new), 96'd1);
    check("wrap bx0 nent0", 96'(nent_of(0)), 96'd1);
    check("wrap bx0 wr_bx", 96'(wr_bx), 96'd0);

    // Repeated BX across an idle gap; idle input carries a different BX
    step(1'b1, 3'd3, 4'd0, 45'h3);
    check("gap first bx_new", 96'(bx_new), 96'd1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 3'd6, 4'd14, 45'h9);
      check($sformatf("gap idle%0d strobes", k), 96'({wr_en, bx_new, err_sel}), 96'd0);
    end
    step(1'b1, 3'd3, 4'd0, 45'h4);
    check("gap again bx_new", 96'(bx_new), 96'd0);
    check("gap again addr", 96'(addr_of(0)), 96'd1);

    // BX change on a full counter, then BX change with invalid sel
    for (int k = 0; k < 65; k++) begin
      step(1'b1, 3'd6, 4'd1, 45'(k));
    end
    check("full ovf1", 96'(ovf), 96'h002);
    step(1'b1, 3'd7, 4'd1, 45'hAA);
    check("full chg bx_new", 96'(bx_new), 96'd1);
    check("full chg wr_en", 96'(wr_en), 96'h002);
    check("full chg addr", 96'(addr_of(1)), 96'd0);
    check("full chg nent1", 96'(nent_of(1)), 96'd64);
    check("full chg ovf", 96'(ovf), 96'd0);
    step(1'b1, 3'd0, 4'd14, 45'hBB);
    e_nent = '0;
    e_nent[1*CW +: CW] = 7'd1;
    check("inv chg flags", 96'({bx_new, err_sel}), 96'b11);
    check("inv chg wr_en", 96'(wr_en), 96'd0);
    check("inv chg nent_prev", 96'(nent_prev), 96'(e_nent));

    // Mid-stream asynchronous reset
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd2, 4'd4, 45'(k));
    end
    check("mid pre addr", 96'(addr_of(4)), 96'd2);
    stream_valid   = 1'b1;
    mem_dat_stream = {3'd2, 4'd4, 45'h7};
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 3'd2, 4'd4, 45'hCC);
    check("mid post bx_new", 96'(bx_new), 96'd1);
    check("mid post wr_en", 96'(wr_en), 96'h010);
    check("mid post addr", 96'(addr_of(4)), 96'd0);
    step(1'b1, 3'd2, 4'd4, 45'hDD);
    check("mid post2 addr", 96'(addr_of(4)), 96'd1);
    check("mid post2 bx_new", 96'(bx_new), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_demux.md
# mem_demux

Receive-side demultiplexer for the 52-bit tagged memory stream `{BX[2:0], sel[3:0], data[44:0]}` produced by the transmit-side port mux. It decodes the port tag, routes each 45-bit word to one of 12 destination memories with a per-destination write-address counter, and tracks bunch-crossing (BX) boundaries. At each boundary it resets the counters and publishes the previous BX's entry counts and overflow status.

## Interface

Parameters:
- `ADDR_W`, default 6: destination memory address width; depth is 2^ADDR_W words per BX.

Ports:
- `clk`: input, 1 bit. Single clock.
- `reset_n`: input, 1 bit. Reset is asynchronous and active-low.
- `stream_valid`: input, 1 bit. `mem_dat_stream` carries a word this cycle.
- `mem_dat_stream`: input, 52 bits. [51:49] BX, [48:45] sel, [44:0] data.
- `wr_en`: output, 12 bits. One-hot write strobe; bit i targets destination i.
- `wr_addr`: output, 12*ADDR_W bits. Slice i, `[i*ADDR_W +: ADDR_W]`, is the write address for destination i.
- `wr_dat`: output, 45 bits. Data word, shared by all destinations.
- `wr_bx`: output, 3 bits. BX of the word being written; used as the page select.
- `bx_new`: output, 1 bit. One-cycle pulse when the first word of a new BX is processed.
- `nent_prev`: output, 12*(ADDR_W+1) bits. Per-destination entry counts of the BX just closed. Updated with `bx_new`.
- `ovf`: output, 12 bits. Per-destination sticky overflow flag for the current BX.
- `err_sel`: output, 1 bit. One-cycle pulse when a word carries an unmapped sel code.

## Operation

- **Sel decode (fixed protocol map):** sel 0000–1001 → destinations 0–9; 1011 → 10; 1100 → 11. The codes 1010, 1101, 1110 and 1111 are invalid.
- **State:**
  - `cur_bx` (3 bits).
  - 12 counters `cnt[i]` (ADDR_W+1 bits each).
  - `ovf[i]`.
  - Output registers.
- **Per accepted word** (`stream_valid`=1):
  1. **BX check.** If the incoming BX ≠ `cur_bx`:
     - `cur_bx` ← incoming BX.
     - `nent_prev[i]` ← `cnt[i]` for all i.
     - All `cnt` ← 0 and all `ovf` ← 0.
     - `bx_new` pulses.
     - The word is then handled against the cleared counters.
  2. **Invalid sel.** `err_sel` pulses and no `wr_en` is asserted. The BX-change processing in step 1 still occurs.
  3. **Valid sel d, `cnt[d]` < 2^ADDR_W:**
     - `wr_en[d]`=1.
     - `wr_addr` slice d = `cnt[d][ADDR_W-1:0]`.
     - `cnt[d]` increments.
  4. **Valid sel d, `cnt[d]` = 2^ADDR_W (full):**
     - The word is dropped; no `wr_en`.
     - `ovf[d]` is set and stays set until the next BX change.
     - `cnt[d]` holds at 2^ADDR_W (saturates).
- **`stream_valid`=0:** no state change. `wr_en`, `bx_new` and `err_sel` are 0.
- **BX comparison is equality only.** A wrap from 7 to 0 is treated as a change like any other. A repeated BX with a gap of idle cycles is not a change.
- **After reset**, `cur_bx`=0. A first word with BX=0 therefore does not pulse `bx_new`.
- **Non-target slices.** `wr_addr` slices for non-written destinations hold their last values. Consumers qualify them with `wr_en`.

## Timing

- **Latency:** one cycle. A word presented at edge N produces `wr_en`, `wr_addr`, `wr_dat`, `wr_bx`, `bx_new` and `err_sel` after edge N+1.
- **`nent_prev` and `ovf`** are registered. Their updated values are visible in the same cycle as the corresponding `bx_new` or write strobe.
- **Throughput:** one word per cycle, back-to-back, with no stall path.
- **Reset values:**
  - All outputs are 0: `wr_en`, `wr_addr`, `wr_dat`, `wr_bx`, `bx_new`, `nent_prev`, `ovf`, `err_sel`.
  - Internal state is 0: `cnt` and `cur_bx`.
- **Reset asserted mid-stream:** all state clears immediately (asynchronous). Words in flight are lost. The first word after deassertion is treated as described above.
- **Simultaneous events:** BX change plus a full counter resolves to counter clear first, so the word is written at address 0. BX change plus invalid sel gives `bx_new` and `err_sel` in the same cycle.

## Structure

- **Shared package `mem_stream_pkg`:**
  - `NDEST=12`.
  - Field positions `BX_MSB/LSB`, `SEL_MSB/LSB`, `DAT_W=45`, `STREAM_W=52`.
  - The sel→destination map as a function `sel2dest()` returning {valid, index[3:0]}.
  - The same package is reused by the transmit mux.
- **Sub-module `mem_wr_counter`:** one instance per destination, generated ×12.
  - Inputs: `clr`, `inc`.
  - Outputs: saturating `cnt` and sticky `ovf`.
- **Top level:** decode, BX tracking and output registers.

## Test plan

- **Routing:** reset, then BX=1 with sel 0000, 0101, 1011, 1100, one per cycle → `wr_en` = 0x001, 0x020, 0x400, 0x800 on successive cycles, each slice address 0, and `bx_new` on the first word only.
- **Invalid sels:** stream sel 1010, 1101, 1111 with BX=0 after reset → `err_sel` pulses ×3, `wr_en`=0, `bx_new` never asserts, all `cnt` unchanged.
- **Overflow (`ADDR_W`=6):** 66 words to destination 3 in one BX → addresses 0..63 written, words 65–66 dropped, `ovf[3]`=1 from the 65th word. Next BX: `nent_prev` slice 3 = 64, `ovf`=0, first write at address 0.
- **BX boundary:** 5 words to destination 2 at BX=4, then a word at BX=5 to destination 2 → `bx_new`=1, `nent_prev` slice 2 = 5, write at address 0.
- **Wrap and gaps:** BX sequence 7→0 → `bx_new` pulses. BX=3, 10 idle cycles, BX=3 → no `bx_new`.
- **Mid-stream reset:** `reset_n` low for 1 cycle during back-to-back traffic → all outputs 0 asynchronously, then counters restart at address 0.
